// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 32-iteration shift-add multiply and restoring divide
// with sign correction, plus direct MTHI/MTLO writes into the result registers.
//
// state | meaning
// IDLE  | waiting; accepts MULT/MULTU/DIV/DIVU or performs MTHI/MTLO
// CALC  | 32 single-bit iterations on the magnitude operands
// FIN   | sign correction, HI/LO write, done pulse
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_mul;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        is_mul_op;
    logic        is_signed_op;
    logic        start_op;
    logic        accept;
    logic        mt_write;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
        start_op     = is_mul_op || (op == OP_DIV) || (op == OP_DIVU);
        accept       = (state == IDLE) && valid && !flush && start_op;
        mt_write     = (state == IDLE) && valid && !flush
                       && ((op == OP_MTHI) || (op == OP_MTLO));
        a_mag        = (is_signed_op && a[31]) ? (32'd0 - a) : a;
        b_mag        = (is_signed_op && b[31]) ? (32'd0 - b) : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign div_diff = {acc[63:32], acc[31]} - {1'b0, opnd};

    // Divide by zero keeps an all-ones quotient regardless of operand signs
    always_comb begin
        prod_fix = neg_q ? (64'd0 - acc) : acc;
        quo_fix  = (neg_q && !div_zero) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == 5'd31) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            is_mul   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= 5'd0;
                        is_mul   <= is_mul_op;
                        neg_q    <= is_signed_op && (a[31] ^ b[31]);
                        neg_r    <= is_signed_op && a[31];
                        div_zero <= !is_mul_op && (b == 32'd0);
                        if (is_mul_op) begin
                            acc  <= {32'd0, b_mag};
                            opnd <= a_mag;
                        end else begin
                            acc  <= {32'd0, a_mag};
                            opnd <= b_mag;
                        end
                    end else if (mt_write) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else begin
                            lo <= a;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        cnt <= cnt + 5'd1;
                        if (is_mul) begin
                            acc <= {mul_sum, acc[31:1]};
                        end else if (!div_diff[32]) begin
                            acc <= {div_diff[31:0], acc[30:0], 1'b1};
                        end else begin
                            acc <= {acc[62:0], 1'b0};
                        end
                    end
                end
                FIN: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_mul) begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed latency/sign/flush/reset cases
// and a short random run, with expected HI/LO results held in a scoreboard queue.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb_q[$];

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference built from the language's own arithmetic, independent of the RTL algorithm
    function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        logic [63:0] p;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        r  = '0;
        sx = x;
        sy = y;
        p  = 64'd0;
        case (o)
            3'b001: begin
                p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
                r = {p[63:32], p[31:0]};
            end
            3'b010: begin
                p = {32'd0, x} * {32'd0, y};
                r = {p[63:32], p[31:0]};
            end
            3'b011: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else r = {32'(sx % sy), 32'(sx / sy)};
            end
            3'b100: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else r = {x % y, x / y};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Presents one op for a single cycle; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        valid = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
    endtask

    // Bounded wait for done; lat counts edges since accept, busy_cycles counts busy-high samples
    task automatic wait_done(output int lat, output int busy_cycles, output bit seen);
        lat         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (hi !== 32'd0)  begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'd0)  begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_mult_signed();
        int lat; int bc; bit seen; res_t exp;
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        issue(3'b001, 32'hFFFFFFFE, 32'h00000003);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL mult_timeout no done within 100 cycles"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL mult_result got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL mult_latency got %0d want 33", lat); end
        n_vec++; if (bc != 33) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_with_done got %b want 0", busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_width got %b want 0", done); end
    endtask

    task automatic test_multu();
        int lat; int bc; bit seen; res_t exp;
        sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL multu_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL multu_result got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
    endtask

    task automatic test_div_signed();
        int lat; int bc; bit seen; res_t exp;
        sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(3'b011, 32'hFFFFFFF9, 32'h00000002);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL div_neg_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL div_neg_result got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
        sb_q.push_back({32'h00000000, 32'h80000000});
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL div_ovf_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL div_ovf_result got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
    endtask

    task automatic test_divu_zero();
        int lat; int bc; bit seen; res_t exp;
        sb_q.push_back({32'h00000064, 32'hFFFFFFFF});
        issue(3'b100, 32'd100, 32'd0);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL divu0_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL divu0_result got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL divu0_latency got %0d want 33", lat); end
    endtask

    task automatic test_flush();
        int dones;
        issue(3'b101, 32'h00000011, 32'd0);
        n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL mthi got %h want 00000011", hi); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", busy); end
        issue(3'b110, 32'h00000022, 32'd0);
        n_vec++; if (lo !== 32'h22) begin n_err++; $display("FAIL mtlo got %h want 00000022", lo); end
        n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL mtlo_keeps_hi got %h want 00000011", hi); end
        // flush in IDLE must block MTHI
        @(negedge clk);
        valid = 1'b1; op = 3'b101; a = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; op = 3'b000; a = 32'd0; flush = 1'b0;
        n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL idle_flush_mthi got %h want 00000011", hi); end
        issue(3'b100, 32'd9, 32'd2);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
        n_vec++; if ({hi, lo} !== {32'h11, 32'h22}) begin n_err++; $display("FAIL flush_hilo got %h_%h want 00000011_00000022", hi, lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL flush_no_done got %0d pulses want 0", dones); end
        issue(3'b110, 32'h00001234, 32'd0);
        n_vec++; if (lo !== 32'h1234) begin n_err++; $display("FAIL mtlo_after_flush got %h want 00001234", lo); end
    endtask

    task automatic test_reset_mid_op();
        int dones; int lat; int bc; bit seen; res_t exp;
        issue(3'b001, 32'h00012345, 32'h00000777);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if ({busy, done, hi, lo} !== 66'd0) begin n_err++; $display("FAIL midrst_outputs got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", dones); end
        sb_q.push_back({32'h00000000, 32'h0000000F});
        issue(3'b010, 32'd3, 32'd5);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL midrst_multu_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL midrst_multu got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
    endtask

    task automatic test_back_to_back();
        int lat; int bc; bit seen; res_t exp;
        sb_q.push_back({32'd2, 32'd14});
        issue(3'b100, 32'd100, 32'd7);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL b2b_first_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL b2b_first got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
        // new op presented in the done cycle
        sb_q.push_back({32'd0, 32'd42});
        valid = 1'b1; op = 3'b010; a = 32'd7; b = 32'd6;
        @(negedge clk);
        valid = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy got %b want 1", busy); end
        // MTHI while busy must be ignored
        valid = 1'b1; op = 3'b101; a = 32'h5555;
        @(negedge clk);
        valid = 1'b0; op = 3'b000; a = 32'd0;
        n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL busy_mthi_ignored got %h want 00000002", hi); end
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL b2b_second_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL b2b_second got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
        sb_q.push_back({32'd1, 32'hFFFFFFFD});
        issue(3'b011, 32'd7, 32'hFFFFFFFE);
        wait_done(lat, bc, seen);
        exp = sb_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL div_negb_timeout no done"); end
        n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL div_negb got %h_%h want %h_%h", hi, lo, exp.hi, exp.lo); end
    endtask

    task automatic test_random();
        int lat; int bc; bit seen; res_t exp;
        logic [2:0] o; logic [31:0] x; logic [31:0] y;
        for (int k = 0; k < 12; k++) begin
            o = 3'($urandom_range(1, 4));
            x = $urandom;
            y = $urandom;
            if (k % 4 == 1) y = 32'($urandom_range(0, 15));
            if (k % 6 == 2) y = ~y;
            sb_q.push_back(model(o, x, y));
            issue(o, x, y);
            wait_done(lat, bc, seen);
            exp = sb_q.pop_front();
            n_vec++; if (!seen) begin n_err++; $display("FAIL rand_timeout op=%0d", o); end
            n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL rand_result op=%0d a=%h b=%h got %h_%h want %h_%h", o, x, y, hi, lo, exp.hi, exp.lo); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
        flush = 1'b0;
        test_reset();
        test_mult_signed();
        test_multu();
        test_div_signed();
        test_divu_zero();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port valid, input, 1 bit: op/a/b valid this cycle.
REQ-005 The block SHALL have port op, input, 3 bits, encoded as: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-006 The block SHALL have port a, input, 32 bits: rs operand (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 The block SHALL have port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-008 The block SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in flight; pipeline stall request.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse; HI/LO hold the new result.
REQ-011 The block SHALL have port hi, output, 32 bits: HI register.
REQ-012 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-013 The block SHALL implement states IDLE, CALC and FIN, with busy = (state != IDLE).
REQ-014 In IDLE, valid=1 with op in {MULT, MULTU, DIV, DIVU} and flush=0 SHALL latch the operands, clear the iteration counter and enter CALC at that edge (the accept edge N).
REQ-015 For MULT and DIV, the operands SHALL be latched as 32-bit absolute values, with result-sign flags recorded: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
REQ-016 CALC SHALL run exactly 32 iterations, one per edge (N+1..N+32): radix-2 shift-add for multiply, restoring shift-subtract for divide; at count 31 it SHALL go to FIN.
REQ-017 At edge N+33, FIN SHALL apply sign correction (two's-complement negate of the 64-bit product, or of the quotient/remainder separately), write hi/lo, set done=1 for exactly one cycle and return to IDLE.
REQ-018 Multiply results SHALL be placed as hi = product[63:32] and lo = product[31:0].
REQ-019 Divide results SHALL be placed as lo = quotient and hi = remainder.
REQ-020 Divide by zero SHALL take the full 34-edge path, raise no exception, and produce lo = 0xFFFFFFFF and hi = a (original unsigned value).
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL produce lo = 0x80000000 and hi = 0x00000000.
REQ-022 In IDLE, MTHI SHALL write hi <= a at the edge (lo unchanged, busy stays 0, no done), and MTLO SHALL likewise write lo <= a.
REQ-023 valid while busy SHALL be ignored; upstream holds the instruction under stall and re-presents it after busy falls.
REQ-024 flush=1 while in CALC or FIN SHALL return the block to IDLE at that edge, with hi/lo unchanged and no done pulse.
REQ-025 flush=1 in IDLE SHALL block acceptance of any op, including MTHI/MTLO.
REQ-026 Priority SHALL be rst > flush > FIN write > accept.
REQ-027 done SHALL never be asserted in the same cycle as busy.
REQ-028 done=1 and valid=1 in the same cycle SHALL be a legal back-to-back case, with the new op accepted.
REQ-029 hi/lo SHALL change only at a FIN write, an MTHI/MTLO write or rst.

Reset
REQ-030 Synchronous rst=1 SHALL set hi = 0, lo = 0, busy = 0, done = 0, state = IDLE and counter = 0, whether the block is idle or mid-operation.
REQ-031 An operation interrupted by rst SHALL be discarded, with no done pulse afterwards.

Verification
REQ-032 The bench SHALL drive MULT a=0xFFFFFFFE, b=0x00000003 and check hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy high for 33 cycles, and done in the cycle after edge N+33.
REQ-033 The bench SHALL drive MULTU a=b=0xFFFFFFFF and check hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 The bench SHALL drive DIV a=0xFFFFFFF9 (-7), b=2 and check lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF and check lo=0x80000000, hi=0.
REQ-035 The bench SHALL drive DIVU a=100, b=0 and check lo=0xFFFFFFFF, hi=0x00000064 with done at normal latency.
REQ-036 The bench SHALL preload hi=0x11, lo=0x22 via MTHI/MTLO, start DIVU 9/2, assert flush at CALC iteration 10, and check busy=0 next cycle, hi/lo still 0x11/0x22 and no done; then drive MTLO a=0x1234 and check lo=0x1234 one edge later.
REQ-037 The bench SHALL assert rst at CALC iteration 20 of a MULT and check all outputs are 0 next cycle and no done follows; then run MULTU 3*5 and check hi=0, lo=0x0000000F.
